// File: rtl/deint_out_ctrl.sv
// deint_out_ctrl: sequences line-FIFO and previous-line reads into a progressive Avalon-ST frame with line averaging.
// Reads issue into a one-cycle read stage that feeds a 2-entry skid FIFO driving the source port.
module deint_out_ctrl #(
    parameter int DATA_WIDTH  = 24,
    parameter int COLOR_BITS  = 8,
    parameter int CHANNELS    = 3,
    parameter int WIDTH       = 720,
    parameter int HALF_HEIGHT = 288
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  ready_to_continue,
    output logic                  aver_sent,
    output logic                  rd_req0,
    output logic                  rd_req1,
    input  logic [DATA_WIDTH-1:0] q0,
    input  logic [DATA_WIDTH-1:0] q1,
    output logic [DATA_WIDTH-1:0] dout_data,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic                  dout_startofpacket,
    output logic                  dout_endofpacket
);
    localparam int PW = (WIDTH > 4) ? $clog2(WIDTH) : 2;
    localparam int EW = (HALF_HEIGHT > 2) ? $clog2(HALF_HEIGHT) : 1;
    localparam int BW = DATA_WIDTH + 2;
    localparam logic [PW-1:0] PX_LAST = PW'(WIDTH - 1);
    localparam logic [EW-1:0] EV_LAST = EW'(HALF_HEIGHT - 2);
    localparam logic [15:0] W16 = 16'(WIDTH);
    localparam logic [15:0] H16 = 16'(2 * HALF_HEIGHT);
    localparam logic [COLOR_BITS:0] ONE = 1;

    typedef enum logic [2:0] {IDLE, CTRL_PKT, VID_HDR, LOAD0, ORIG, AVG, TAIL_ORIG, TAIL_DUP} state_t;
    typedef enum logic [1:0] {SRC_CTRL, SRC_FIFO, SRC_PREV, SRC_AVG} src_t;

    state_t state_q, state_d;
    src_t s1_src_q, s1_src_d;
    logic [PW-1:0] px_q, px_d, s1_px_q;
    logic [EW-1:0] ev_q, ev_d;
    logic armed_q, armed_d, aver_q, aver_d;
    logic s1_v_q, s1_v_d, s1_sel_q, s1_sel_d, s1_wr_q, s1_wr_d;
    logic s1_sop_q, s1_sop_d, s1_eop_q, s1_eop_d;
    logic [DATA_WIDTH-1:0] s1_dat_q, s1_dat_d, ctrl_w, fifo_q, avg_w, pw_data, prev_rd_q;
    logic [DATA_WIDTH-1:0] prev_mem [WIDTH];
    logic [BW-1:0] e0_q, e0_d, e1_q, e1_d, push_beat;
    logic [1:0] occ_q, occ_d, slot;
    logic pop, ok, last;

    assign dout_valid         = occ_q != 2'd0;
    assign pop                = dout_valid && dout_ready;
    assign dout_data          = e0_q[DATA_WIDTH-1:0];
    assign dout_startofpacket = dout_valid & e0_q[BW-1];
    assign dout_endofpacket   = dout_valid & e0_q[BW-2];
    assign aver_sent          = aver_q;
    // a beat issued now lands in the skid next cycle, so count the one already in flight
    assign ok   = ({1'b0, occ_q} + {2'b0, s1_v_q} - {2'b0, pop}) < 3'd2;
    assign last = px_q == PX_LAST;

    assign ctrl_w = px_q[1:0] == 2'd0 ? DATA_WIDTH'(24'h00000F) :
                    px_q[1:0] == 2'd1 ? DATA_WIDTH'({4'h0, W16[7:4], 4'h0, W16[11:8], 4'h0, W16[15:12]}) :
                    px_q[1:0] == 2'd2 ? DATA_WIDTH'({4'h0, H16[11:8], 4'h0, H16[15:12], 4'h0, W16[3:0]}) :
                                        DATA_WIDTH'({8'h03, 4'h0, H16[3:0], 4'h0, H16[7:4]});

    assign fifo_q = s1_sel_q ? q1 : q0;
    for (genvar i = 0; i < CHANNELS; i++) begin : g_avg
        logic [COLOR_BITS:0] sum;
        assign sum = {1'b0, fifo_q[i*COLOR_BITS +: COLOR_BITS]} + {1'b0, prev_rd_q[i*COLOR_BITS +: COLOR_BITS]} + ONE;
        assign avg_w[i*COLOR_BITS +: COLOR_BITS] = sum[COLOR_BITS:1];
    end

    assign pw_data = s1_src_q == SRC_CTRL ? s1_dat_q :
                     s1_src_q == SRC_FIFO ? fifo_q :
                     s1_src_q == SRC_PREV ? prev_rd_q : avg_w;
    assign push_beat = {s1_sop_q, s1_eop_q, pw_data};
    assign slot      = occ_q - {1'b0, pop};

    always_comb begin
        e0_d  = pop ? e1_q : e0_q;
        e1_d  = e1_q;
        occ_d = occ_q + {1'b0, s1_v_q} - {1'b0, pop};
        if (s1_v_q && slot == 2'd0) e0_d = push_beat;
        if (s1_v_q && slot != 2'd0) e1_d = push_beat;
    end

    always_comb begin
        state_d  = state_q;
        px_d     = px_q;
        ev_d     = ev_q;
        aver_d   = 1'b0;
        armed_d  = ready_to_continue ? armed_q : 1'b1;
        rd_req0  = 1'b0;
        rd_req1  = 1'b0;
        s1_v_d   = 1'b0;
        s1_src_d = SRC_PREV;
        s1_sel_d = 1'b0;
        s1_wr_d  = 1'b0;
        s1_sop_d = 1'b0;
        s1_eop_d = 1'b0;
        s1_dat_d = '0;
        if (state_q == IDLE) begin
            if (ready_to_continue && armed_q) begin
                state_d = ev_q == '0 ? CTRL_PKT : ORIG;
                px_d    = '0;
            end
        end else if (ok) begin
            s1_v_d = 1'b1;
            px_d   = last ? '0 : px_q + PW'(1);
            case (state_q)
                CTRL_PKT: begin
                    s1_src_d = SRC_CTRL;
                    s1_dat_d = ctrl_w;
                    s1_sop_d = px_q == '0;
                    s1_eop_d = px_q == PW'(3);
                    px_d     = px_q == PW'(3) ? '0 : px_q + PW'(1);
                    state_d  = px_q == PW'(3) ? VID_HDR : CTRL_PKT;
                end
                VID_HDR: begin
                    s1_src_d = SRC_CTRL;
                    s1_sop_d = 1'b1;
                    px_d     = '0;
                    state_d  = LOAD0;
                end
                LOAD0: begin
                    rd_req0  = 1'b1;
                    s1_src_d = SRC_FIFO;
                    s1_wr_d  = 1'b1;
                    state_d  = last ? AVG : LOAD0;
                end
                ORIG: state_d = last ? AVG : ORIG;
                AVG: begin
                    rd_req0  = ev_q[0];
                    rd_req1  = !ev_q[0];
                    s1_sel_d = !ev_q[0];
                    s1_src_d = SRC_AVG;
                    s1_wr_d  = 1'b1;
                    if (last) begin
                        // disarm so a still-high ready_to_continue cannot retrigger
                        aver_d  = 1'b1;
                        armed_d = !ready_to_continue;
                        state_d = ev_q == EV_LAST ? TAIL_ORIG : IDLE;
                        ev_d    = ev_q == EV_LAST ? ev_q : ev_q + EW'(1);
                    end
                end
                TAIL_ORIG: state_d = last ? TAIL_DUP : TAIL_ORIG;
                TAIL_DUP: begin
                    s1_eop_d = last;
                    state_d  = last ? IDLE : TAIL_DUP;
                    ev_d     = last ? '0 : ev_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            px_q     <= '0;
            ev_q     <= '0;
            armed_q  <= 1'b1;
            aver_q   <= 1'b0;
            s1_v_q   <= 1'b0;
            s1_src_q <= SRC_CTRL;
            s1_sel_q <= 1'b0;
            s1_wr_q  <= 1'b0;
            s1_sop_q <= 1'b0;
            s1_eop_q <= 1'b0;
            s1_dat_q <= '0;
            s1_px_q  <= '0;
            e0_q     <= '0;
            e1_q     <= '0;
            occ_q    <= '0;
        end else begin
            state_q  <= state_d;
            px_q     <= px_d;
            ev_q     <= ev_d;
            armed_q  <= armed_d;
            aver_q   <= aver_d;
            s1_v_q   <= s1_v_d;
            s1_src_q <= s1_src_d;
            s1_sel_q <= s1_sel_d;
            s1_wr_q  <= s1_wr_d;
            s1_sop_q <= s1_sop_d;
            s1_eop_q <= s1_eop_d;
            s1_dat_q <= s1_dat_d;
            s1_px_q  <= px_q;
            e0_q     <= e0_d;
            e1_q     <= e1_d;
            occ_q    <= occ_d;
        end
    end

    // prev line RAM: read address is the current pixel, write lands one cycle later
    always_ff @(posedge clock) begin
        if (s1_v_q && s1_wr_q) prev_mem[s1_px_q] <= fifo_q;
        prev_rd_q <= prev_mem[px_q];
    end
endmodule

// File: tb/tb_deint_out_ctrl.sv
// tb_deint_out_ctrl: directed bench for deint_out_ctrl with FIFO models and a beat scoreboard.
module tb_deint_out_ctrl;
    localparam int W = 4;
    localparam int HH = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;
    logic ready_to_continue = 1'b0;
    logic dout_ready = 1'b1;
    logic [23:0] q0 = '0, q1 = '0;
    logic aver_sent, rd_req0, rd_req1, dout_valid, dout_startofpacket, dout_endofpacket;
    logic [23:0] dout_data;

    int n_cmp = 0, n_err = 0;
    int rd0_cnt = 0, rd1_cnt = 0, aver_cnt = 0;
    bit rand_ready = 1'b0;
    logic [25:0] got[$], exp_q[$];
    logic [23:0] f0[$], f1[$];

    deint_out_ctrl #(.DATA_WIDTH(24), .COLOR_BITS(8), .CHANNELS(3), .WIDTH(W), .HALF_HEIGHT(HH)) dut (
        .clock(clock), .reset(reset), .ready_to_continue(ready_to_continue), .aver_sent(aver_sent),
        .rd_req0(rd_req0), .rd_req1(rd_req1), .q0(q0), .q1(q1), .dout_data(dout_data),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_startofpacket(dout_startofpacket), .dout_endofpacket(dout_endofpacket)
    );

    initial forever #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        n_cmp++;
        assert (o === e) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    function automatic logic [23:0] pix(input logic [23:0] b, input logic [23:0] s, input int p);
        return b + s * 24'(p);
    endfunction

    function automatic logic [23:0] avg24(input logic [23:0] a, input logic [23:0] b);
        logic [23:0] r;
        for (int c = 0; c < 3; c++) r[8*c +: 8] = 8'((int'(a[8*c +: 8]) + int'(b[8*c +: 8]) + 1) / 2);
        return r;
    endfunction

    // FIFO models, output capture, stall stability and handshake checks
    initial begin
        bit stall = 1'b0, aver_prev = 1'b0, r0, r1;
        logic [25:0] stall_beat = '0;
        forever begin
            @(negedge clock);
            if (stall && reset) chk("stall_hold", {dout_valid, dout_startofpacket, dout_endofpacket, dout_data}, {1'b1, stall_beat});
            stall = dout_valid && !dout_ready;
            stall_beat = {dout_startofpacket, dout_endofpacket, dout_data};
            if (dout_valid && dout_ready) got.push_back({dout_startofpacket, dout_endofpacket, dout_data});
            if (rd_req0 || rd_req1) chk("rd_exclusive", 32'(rd_req0 & rd_req1), 0);
            if (rd_req0) chk("f0_overread", 32'(f0.size() != 0), 1);
            if (rd_req1) chk("f1_overread", 32'(f1.size() != 0), 1);
            if (aver_sent) begin
                aver_cnt++;
                chk("aver_width", 32'(aver_prev), 0);
            end
            aver_prev = aver_sent;
            r0 = rd_req0;
            r1 = rd_req1;
            rd0_cnt += int'(r0);
            rd1_cnt += int'(r1);
            @(posedge clock);
            #1;
            if (r0 && f0.size() != 0) q0 = f0.pop_front();
            if (r1 && f1.size() != 0) q1 = f1.pop_front();
        end
    end

    initial forever begin
        @(posedge clock);
        #1;
        dout_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic push_line(input bit sel, input logic [23:0] b, input logic [23:0] s);
        for (int p = 0; p < W; p++) if (sel) f1.push_back(pix(b, s, p)); else f0.push_back(pix(b, s, p));
    endtask

    task automatic exp_line(input logic [23:0] b, input logic [23:0] s, input bit eop);
        for (int p = 0; p < W; p++) exp_q.push_back({1'b0, eop && p == W - 1, pix(b, s, p)});
    endtask

    task automatic exp_avg(input logic [23:0] b0, input logic [23:0] s0, input logic [23:0] b1, input logic [23:0] s1);
        for (int p = 0; p < W; p++) exp_q.push_back({2'b00, avg24(pix(b0, s0, p), pix(b1, s1, p))});
    endtask

    task automatic wait_aver(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clock);
            seen = aver_sent;
        end
        chk(tag, 32'(seen), 1);
        tick(1);
    endtask

    // sink side of one field: two events, ready_to_continue held 4 cycles past each aver_sent
    task automatic sink_field(input logic [23:0] b0, s0, b1, s1, b2, s2, input bit lat);
        exp_q.push_back({2'b10, 24'h00000F});
        exp_q.push_back({2'b00, 24'h000000});
        exp_q.push_back({2'b00, 24'h000004});
        exp_q.push_back({2'b01, 24'h030600});
        exp_q.push_back({2'b10, 24'h000000});
        exp_line(b0, s0, 1'b0);
        exp_avg(b0, s0, b1, s1);
        exp_line(b1, s1, 1'b0);
        exp_avg(b1, s1, b2, s2);
        exp_line(b2, s2, 1'b0);
        exp_line(b2, s2, 1'b1);
        push_line(1'b0, b0, s0);
        push_line(1'b1, b1, s1);
        ready_to_continue = 1'b1;
        if (lat) begin
            repeat (3) @(negedge clock);
            chk("latency_pre", 32'(dout_valid), 0);
            @(negedge clock);
            chk("latency_first", 32'(dout_valid), 1);
        end
        wait_aver("aver_ev0");
        tick(3);
        ready_to_continue = 1'b0;
        tick(2);
        push_line(1'b0, b2, s2);
        ready_to_continue = 1'b1;
        wait_aver("aver_ev1");
        tick(3);
        ready_to_continue = 1'b0;
        tick(1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000 && got.size() < exp_q.size(); i++) tick(1);
        tick(6);
    endtask

    task automatic compare_all(input int nf);
        chk("beat_count", got.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) chk($sformatf("beat%0d", i), (i < got.size()) ? 32'(got[i]) : 32'hDEAD, 32'(exp_q[i]));
        chk("aver_count", aver_cnt, 2 * nf);
        chk("rd0_count", rd0_cnt, 2 * W * nf);
        chk("rd1_count", rd1_cnt, W * nf);
        chk("f0_drained", f0.size(), 0);
        chk("f1_drained", f1.size(), 0);
        got.delete();
        exp_q.delete();
        aver_cnt = 0;
        rd0_cnt = 0;
        rd1_cnt = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_aver"}, 32'(aver_sent), 0);
        chk({tag, "_rd0"}, 32'(rd_req0), 0);
        chk({tag, "_rd1"}, 32'(rd_req1), 0);
        chk({tag, "_valid"}, 32'(dout_valid), 0);
        chk({tag, "_sop"}, 32'(dout_startofpacket), 0);
        chk({tag, "_eop"}, 32'(dout_endofpacket), 0);
        chk({tag, "_data"}, 32'(dout_data), 0);
    endtask

    initial begin
        tick(3);
        chk_reset_outputs("reset");
        reset = 1'b1;
        tick(2);

        sink_field(24'h101010, 24'h0, 24'h131313, 24'h0, 24'h202020, 24'h000001, 1'b1);
        wait_done();
        compare_all(1);

        sink_field(24'hFF00FF, 24'h0, 24'hFF01FE, 24'h0, 24'h000000, 24'h010101, 1'b0);
        sink_field(24'h0A0B0C, 24'h010203, 24'hF0E0D0, 24'hFFFFFF, 24'h555555, 24'h020202, 1'b0);
        wait_done();
        chk("avg_boundary", (got.size() > 9) ? 32'(got[9]) : 32'hDEAD, 32'h00FF01FF);
        chk("second_ctrl_beat0", (got.size() > 29) ? 32'(got[29]) : 32'hDEAD, {6'd0, 2'b10, 24'h00000F});
        compare_all(2);

        rand_ready = 1'b1;
        sink_field(24'h123456, 24'h010101, 24'h654321, 24'h000100, 24'h808080, 24'h000001, 1'b0);
        wait_done();
        rand_ready = 1'b0;
        compare_all(1);

        push_line(1'b0, 24'h111111, 24'h0);
        push_line(1'b1, 24'h222222, 24'h0);
        ready_to_continue = 1'b1;
        wait_aver("abort_ev0");
        tick(3);
        ready_to_continue = 1'b0;
        tick(2);
        push_line(1'b0, 24'h333333, 24'h0);
        ready_to_continue = 1'b1;
        tick(6);
        reset = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        ready_to_continue = 1'b0;
        tick(3);
        chk_reset_outputs("held_reset");
        f0.delete();
        f1.delete();
        got.delete();
        exp_q.delete();
        aver_cnt = 0;
        rd0_cnt = 0;
        rd1_cnt = 0;
        reset = 1'b1;
        tick(2);

        sink_field(24'hA0A0A0, 24'h010101, 24'h0F0F0F, 24'h000002, 24'hFEFEFE, 24'h0, 1'b0);
        wait_done();
        compare_all(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
